// File: rtl/layer_seq_ctrl.sv
// Multi-layer sequencer: for each layer, kick the loaders, wait for load_done,
// kick the layering unit, wait for layer_done; a watchdog guards both waits.
//
// state        | meaning
// S_IDLE       | waiting for start with a non-zero layer count
// S_LOAD       | one-cycle weight/input/valid-pipeline kick
// S_WAIT_LOAD  | waiting for load_done, watchdog running
// S_LAYER      | one-cycle layering kick
// S_WAIT_LAYER | waiting for layer_done, watchdog running
// S_DONE       | one-cycle completion pulse
module layer_seq_ctrl #(
    parameter int LAYER_W   = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [LAYER_W-1:0] num_layers_i,
    input  logic               load_done_i,
    input  logic               layer_done_i,
    output logic [2:0]         mode_o,
    output logic               start_weights_o,
    output logic               start_input_o,
    output logic               start_valid_pipeline_o,
    output logic               start_layering_o,
    output logic [LAYER_W-1:0] layer_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOAD,
        S_LAYER,
        S_WAIT_LAYER,
        S_DONE
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMAX = '1;

    state_t               state_q, state_d;
    logic [LAYER_W-1:0]   num_q, num_d;
    logic [LAYER_W-1:0]   idx_q, idx_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 terr_q, terr_d;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic [LAYER_W-1:0]   last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    // Saturating increment: expiry is taken the cycle the count reaches TMAX.
    assign wdog_inc = (wdog_q == TMAX) ? wdog_q : wdog_q + 1'b1;
    assign last_idx = num_q - 1'b1;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (num_layers_i != '0)) begin
                    num_d   = num_layers_i;
                    idx_d   = '0;
                    terr_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                wdog_d  = '0;
                state_d = S_WAIT_LOAD;
            end
            S_WAIT_LOAD: begin
                wdog_d = wdog_inc;
                if (wdog_inc == TMAX) begin
                    terr_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else if (load_done_i) begin
                    state_d = S_LAYER;
                end
            end
            S_LAYER: begin
                wdog_d  = '0;
                state_d = S_WAIT_LAYER;
            end
            S_WAIT_LAYER: begin
                wdog_d = wdog_inc;
                if (wdog_inc == TMAX) begin
                    terr_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else if (layer_done_i) begin
                    if (idx_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // Abort outranks everything, including a same-cycle watchdog expiry.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            terr_d  = terr_q;
        end
    end

    assign mode_o = ((state_q == S_LOAD)  || (state_q == S_WAIT_LOAD))  ? 3'd1 :
                    ((state_q == S_LAYER) || (state_q == S_WAIT_LAYER)) ? 3'd2 : 3'd0;
    assign start_weights_o        = (state_q == S_LOAD);
    assign start_input_o          = (state_q == S_LOAD);
    assign start_valid_pipeline_o = (state_q == S_LOAD);
    assign start_layering_o       = (state_q == S_LAYER);
    assign busy_o                 = (state_q != S_IDLE);
    assign done_o                 = (state_q == S_DONE);
    assign layer_idx_o            = idx_q;
    assign timeout_err_o          = terr_q;

endmodule

// File: doc/layer_seq_ctrl.md
LAYER_SEQ_CTRL -- requirements
Module: layer_seq_ctrl

Interface
REQ-001 Parameter LAYER_W, default 4: width of the layer count and layer index.
REQ-002 Parameter TIMEOUT_W, default 8: width of the wait-state watchdog counter; the limit is TMAX = 2^TIMEOUT_W - 1 cycles.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to run a multi-layer sequence; sampled only in IDLE.
REQ-006 abort  in  1  cancel the current sequence; sampled in every non-IDLE state.
REQ-007 num_layers  in  LAYER_W  layer count; latched into num_q when start is accepted.
REQ-008 load_done  in  1  completion from the weight/input loaders.
REQ-009 layer_done  in  1  completion from the layering unit.
REQ-010 mode  out  3  0 = idle, 1 = load, 2 = layer.
REQ-011 start_weights, start_input, start_valid_pipeline  out  1 each  one-cycle load kicks.
REQ-012 start_layering  out  1  one-cycle layer kick.
REQ-013 layer_idx  out  LAYER_W  index of the current layer, 0-based.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse on normal completion.
REQ-016 timeout_err  out  1  sticky watchdog flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT_LOAD, LAYER, WAIT_LAYER, DONE; all outputs SHALL be driven from registers or state decode, with no combinational path from any input to any output.
REQ-018 In IDLE with start=1 and num_layers!=0: latch num_q, set layer_idx=0, clear timeout_err, go to LOAD.
REQ-019 In IDLE with start=1 and num_layers=0: ignore start; state and outputs unchanged.
REQ-020 LOAD SHALL last exactly 1 cycle with start_weights=start_input=start_valid_pipeline=1, then go to WAIT_LOAD.
REQ-021 WAIT_LOAD: load_done=1 -> LAYER; load_done is ignored while in LOAD.
REQ-022 LAYER SHALL last exactly 1 cycle with start_layering=1, then go to WAIT_LAYER.
REQ-023 WAIT_LAYER: layer_done=1 and layer_idx==num_q-1 -> DONE.
REQ-024 WAIT_LAYER: layer_done=1 otherwise -> layer_idx+1 and LOAD, so weights are reloaded for every layer.
REQ-025 DONE SHALL last 1 cycle with done=1, then go to IDLE; start is ignored in DONE.
REQ-026 mode SHALL be 1 in LOAD/WAIT_LOAD, 2 in LAYER/WAIT_LAYER, and 0 in IDLE/DONE.
REQ-027 All kick pulses SHALL be 0 in every state other than those named in REQ-020 and REQ-022.
REQ-028 Latency: start sampled at edge k -> load kicks high in cycle k+1; load_done sampled at edge j -> start_layering high in cycle j+1.
REQ-029 Watchdog: counter cleared on entry to WAIT_LOAD or WAIT_LAYER and incremented each cycle there without the matching done input.
REQ-030 Watchdog: on reaching TMAX -> timeout_err=1 and go to IDLE, with no done pulse; the counter SHALL saturate and never wrap.
REQ-031 abort=1 in any non-IDLE state -> IDLE next edge, layer_idx=0, no kick or done pulse in that next cycle.
REQ-032 Priority: abort > watchdog expiry > load_done/layer_done.
REQ-033 Changes to num_layers while busy SHALL have no effect, since num_q is used.
REQ-034 load_done/layer_done asserted outside their wait state SHALL be ignored and not remembered.
REQ-035 layer_idx SHALL never exceed num_q-1; num_layers = 2^LAYER_W - 1 SHALL run fully without wrap.

Reset
REQ-036 While rst_n=0, asynchronously: state=IDLE, mode=0, all kick pulses=0, layer_idx=0, busy=0, done=0, timeout_err=0, watchdog counter=0, num_q=0.
REQ-037 Reset asserted mid-sequence SHALL abandon the sequence, with no done pulse on release.
REQ-038 After rst_n rises, the first start SHALL be accepted on the first clock edge where it is sampled high.

Verification
REQ-039 start with num_layers=1; load_done 3 cycles after the kick; layer_done 4 cycles after start_layering -> exactly one set of load kicks, one start_layering, done=1 for one cycle, busy back to 0, mode sequence 1,2,0.
REQ-040 num_layers=3 -> three load+layer rounds, layer_idx 0,1,2, a single done pulse; num_layers changed to 7 mid-run has no effect.
REQ-041 start with num_layers=0 -> busy stays 0, no pulses; start while busy -> ignored.
REQ-042 TIMEOUT_W=4, load_done never asserted -> timeout_err=1 after 15 cycles in WAIT_LOAD, IDLE, no done; the next accepted start clears timeout_err.
REQ-043 abort in WAIT_LAYER, same cycle as layer_done -> IDLE, layer_idx=0, no LOAD, no done.
REQ-044 rst_n pulled low in WAIT_LOAD with no clock edge -> all outputs 0 immediately.
